jtframe_pulse_gen: RTL

- Transmit side of the edge-latch interrupt/event interface.
- Accepts single-cycle event requests from the core and queues them in a saturating counter.
- Replays each queued event as a clean pulse on one output line, with programmable width and a minimum low gap, so that a downstream rising-edge latch in any clock domain captures every event exactly once.
- Placed between game-logic event sources (VBL, timer, sound-CPU command) and CPU interrupt latches.

---
 rtl/jtframe_sat_cnt.sv | 30 +++
 rtl/jtframe_pulse_gen.sv | 109 ++++++++++
 2 files changed

// File: rtl/jtframe_sat_cnt.sv
// Up/down saturating counter: clr wins, inc and dec together cancel,
// inc holds at all-ones and dec holds at zero.
`timescale 1ns/1ps
module jtframe_sat_cnt #(
  parameter int W = 3
) (
  input  logic         rst,
  input  logic         clk,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         full
);

  assign full = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/jtframe_pulse_gen.sv
// Event-to-pulse transmitter: queues single-cycle requests and replays each
// as a PW-wide pulse followed by a GAP-wide inactive time, timed in cen ticks.
`timescale 1ns/1ps
module jtframe_pulse_gen #(
  parameter int PW  = 4,
  parameter int GAP = 4,
  parameter int QW  = 3,
  parameter int POL = 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          req,
  input  logic          flush,
  output logic          pout,
  output logic          busy,
  output logic [QW-1:0] pending,
  output logic          ovf
);

  localparam int TMAX = (PW > GAP) ? PW : GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic ACT = POL[0];
  localparam logic [TW-1:0] PW_LD  = TW'(PW - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP - 1);

  if (PW < 1 || PW > 255 || GAP < 1 || GAP > 255 || QW < 1) begin : g_bad_params
    $error("jtframe_pulse_gen: PW and GAP must be 1..255 and QW at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          full;
  logic          start;

  // A start consumes one queued event in the same cycle a new req may land.
  assign start = cen && (state == ST_IDLE) && (pending != '0);

  jtframe_sat_cnt #(.W(QW)) u_pending (
    .rst  (rst),
    .clk  (clk),
    .inc  (req),
    .dec  (start),
    .clr  (flush),
    .cnt  (pending),
    .full (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (flush) begin
      ovf <= 1'b0;
    end else if (req && full && !start) begin
      ovf <= 1'b1;
    end
  end

  // Flush does not touch the FSM: a running pulse always finishes with its gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
      pout  <= ~ACT;
      busy  <= 1'b0;
    end else if (cen) begin
      case (state)
        ST_IDLE: begin
          if (pending != '0) begin
            state <= ST_HIGH;
            timer <= PW_LD;
            pout  <= ACT;
            busy  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (timer == '0) begin
            state <= ST_GAP;
            timer <= GAP_LD;
            pout  <= ~ACT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_GAP: begin
          if (timer == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
          pout  <= ~ACT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
